cave_filler: RTL and testbench
==============================

Name: cave_filler

Overview:
- Downstream consumer of the 8-bit pseudo-random `generator` (its `count` output).
- Walks a WIDTH x HEIGHT cave grid in raster order and emits one tile write per cell into the tile RAM.
- Border cells get steel wall.
- Each interior cell consumes one random byte, which is compared against four per-object probability thresholds to pick the tile.
- Pulses `gen_en` to step the generator exactly once per interior cell.

Parameters:
- WIDTH, 40, cave columns (>=3).
- HEIGHT, 22, cave rows (>=3).
- ADDR_W, 10, tile RAM address width; WIDTH*HEIGHT <= 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- res  in  1  synchronous active-high reset.
- start  in  1  begin a fill; sampled only in IDLE.
- prob  in  32  four 8-bit thresholds, object i = prob[8i+7:8i].
- kind  in  16  four 4-bit tile codes, object i = kind[4i+3:4i].
- rnd  in  8  current generator value (generator `count`).
- gen_en  out  1  step request to generator (drives generator `en`).
- wr_en  out  1  tile write strobe.
- wr_addr  out  ADDR_W  tile address = row*WIDTH+col.
- wr_data  out  4  tile code.
- wr_ready  in  1  RAM accepts the write this cycle.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last write is accepted.

Behaviour:
- Clock and reset: one clock `clk`; reset `res` is synchronous and active-high.
- Reset values:
  - State IDLE; row = col = 0.
  - gen_en, wr_en, busy and done are 0.
  - wr_addr = 0; wr_data = TILE_DIRT.
- Reset mid-fill: same as above on the next edge. No further writes; no done pulse.
- States: IDLE, FILL, DONE.
- IDLE:
  - start=1 latches prob and kind into internal registers (later input changes ignored until next start).
  - Clears row, col and the address counter, then goes to FILL.
- FILL:
  - wr_en is high every cycle.
  - wr_addr tracks an incremental counter (no multiplier).
- A cell is a border cell when row==0, row==HEIGHT-1, col==0 or col==WIDTH-1. For a border cell:
  - wr_data = TILE_STEEL.
  - gen_en = 0.
- Interior cell tile selection:
  - Start with TILE_DIRT.
  - For i = 0..3 in order, if rnd < prob_i (unsigned, strict) the tile becomes kind_i. The highest matching index wins.
  - prob_i = 0 never matches; prob_i = 255 matches all rnd except 255.
  - wr_data is combinational from rnd in the same cycle.
- gen_en for an interior cell:
  - gen_en = wr_ready, so the generator steps only when the write commits.
  - A stalled interior write therefore keeps the same rnd and the same wr_data.
- Advance happens only when wr_en && wr_ready:
  - col++; at col==WIDTH-1, col wraps to 0 and row++.
  - The address counter increments by 1.
- When the cell at (HEIGHT-1, WIDTH-1) commits: go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
  - start in DONE is ignored.
- start while busy is ignored.
- Totals per fill:
  - Exactly WIDTH*HEIGHT writes.
  - Exactly (WIDTH-2)*(HEIGHT-2) gen_en pulses.
- Latency: start at edge N gives the first write visible in cycle N+1; with wr_ready held high, done is high in cycle N+1+WIDTH*HEIGHT.

Decomposition:
- Package `dash_pkg`:
  - TILE_W=4.
  - Tile codes TILE_SPACE=4'h0, TILE_DIRT=4'h1, TILE_BRICK=4'h2, TILE_BOULDER=4'h3, TILE_DIAMOND=4'h4, TILE_STEEL=4'h7.
  - State encoding for IDLE/FILL/DONE.
- One sub-module, `tile_select`: combinational rnd/prob/kind -> tile code, so it can be unit-checked independently.
- The raster counter stays inline.

Test Plan:
1. WIDTH=4, HEIGHT=3; prob=0, wr_ready=1, start pulse -> 12 writes at addr 0..11:
   - Steel at all except addr 5 and 6, which are TILE_DIRT.
   - Exactly 2 gen_en pulses.
   - done one cycle at start+13.
2. prob={8'd0,8'd0,8'd0,8'd128}, kind[3:0]=TILE_BOULDER, rnd forced 127 then 128:
   - addr 5 gets 4'h3.
   - addr 6 gets TILE_DIRT.
3. Overlap: prob all 8'd200, kind={4,3,2,1}, rnd=10 -> interior tiles = 4'h4 (highest index wins).
4. wr_ready low for 3 cycles on addr 5:
   - wr_en, wr_addr=5 and wr_data are held.
   - gen_en stays 0 during the stall and pulses once on accept.
   - Total gen_en count is still 2.
5. res asserted after the 4th accepted write:
   - Next cycle wr_en=0, busy=0, gen_en=0, done never pulses.
   - A new start restarts from addr 0.
6. start re-pulsed mid-fill and during DONE -> ignored; write count 12, one done pulse; prob changed mid-fill has no effect.

Source files
------------

// File: rtl/dash_pkg.sv
// Shared tile codes, field widths and fill-FSM state encoding for the cave filler.
package dash_pkg;

    localparam int unsigned TILE_W  = 4;
    localparam int unsigned PROB_W  = 8;
    localparam int unsigned NUM_OBJ = 4;

    localparam logic [TILE_W-1:0] TILE_SPACE   = 4'h0;
    localparam logic [TILE_W-1:0] TILE_DIRT    = 4'h1;
    localparam logic [TILE_W-1:0] TILE_BRICK   = 4'h2;
    localparam logic [TILE_W-1:0] TILE_BOULDER = 4'h3;
    localparam logic [TILE_W-1:0] TILE_DIAMOND = 4'h4;
    localparam logic [TILE_W-1:0] TILE_STEEL   = 4'h7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/tile_select.sv
// Picks an interior tile from one random byte against four object thresholds.
//   rnd_i  : random byte
//   prob_i : four 8-bit thresholds, object i in bits [8i+7:8i]
//   kind_i : four 4-bit tile codes, object i in bits [4i+3:4i]
//   tile_o : selected tile (combinational)
module tile_select
    import dash_pkg::*;
(
    input  logic [PROB_W-1:0]         rnd_i,
    input  logic [NUM_OBJ*PROB_W-1:0] prob_i,
    input  logic [NUM_OBJ*TILE_W-1:0] kind_i,
    output logic [TILE_W-1:0]         tile_o
);

    // Later objects override earlier ones, so the highest matching index wins.
    always_comb begin
        tile_o = TILE_DIRT;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            if (rnd_i < prob_i[i*PROB_W +: PROB_W]) begin
                tile_o = kind_i[i*TILE_W +: TILE_W];
            end
        end
    end

endmodule

// File: rtl/cave_filler.sv
// Raster-walks a WIDTH x HEIGHT cave and writes one tile per cell into tile RAM.
//   clk, res      : clock, synchronous active-high reset
//   start         : begin a fill (honoured only in IDLE)
//   prob, kind    : per-object thresholds / tile codes, latched at start
//   rnd           : current generator byte
//   gen_en        : generator step, one per committed interior write
//   wr_en/addr/data, wr_ready : tile RAM write port with back-pressure
//   busy, done    : fill in progress / one-cycle completion pulse
module cave_filler
    import dash_pkg::*;
#(
    parameter int unsigned WIDTH  = 40,
    parameter int unsigned HEIGHT = 22,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic                      start,
    input  logic [NUM_OBJ*PROB_W-1:0] prob,
    input  logic [NUM_OBJ*TILE_W-1:0] kind,
    input  logic [PROB_W-1:0]         rnd,
    output logic                      gen_en,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [TILE_W-1:0]         wr_data,
    input  logic                      wr_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    fill_state_e                 state_q, state_d;
    logic [ROW_W-1:0]            row_q, row_d;
    logic [COL_W-1:0]            col_q, col_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [NUM_OBJ*PROB_W-1:0]   prob_q, prob_d;
    logic [NUM_OBJ*TILE_W-1:0]   kind_q, kind_d;
    logic                        border_c;
    logic [TILE_W-1:0]           sel_tile_c;

    tile_select u_tile_select (
        .rnd_i  (rnd),
        .prob_i (prob_q),
        .kind_i (kind_q),
        .tile_o (sel_tile_c)
    );

    assign border_c = (row_q == '0) || (row_q == ROW_LAST) ||
                      (col_q == '0) || (col_q == COL_LAST);

    // Address is a running counter kept alongside row/col, avoiding row*WIDTH.
    assign wr_addr = addr_q;

    // State and raster registers.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            prob_q  <= '0;
            kind_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            prob_q  <= prob_d;
            kind_q  <= kind_d;
        end
    end

    // Next-state, raster advance and write-port outputs.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        prob_d  = prob_q;
        kind_d  = kind_q;
        wr_en   = 1'b0;
        gen_en  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        wr_data = TILE_DIRT;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                    prob_d  = prob;
                    kind_d  = kind;
                end
            end
            ST_FILL: begin
                wr_en   = 1'b1;
                busy    = 1'b1;
                wr_data = border_c ? TILE_STEEL : sel_tile_c;
                // Step the generator only when this interior write commits,
                // so a stalled write keeps the same rnd and tile.
                gen_en  = !border_c && wr_ready;
                if (wr_ready) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                        if (row_q == ROW_LAST) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cave_filler.sv
module tb_cave_filler;
    import dash_pkg::*;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        res;
    logic        start;
    logic [31:0] prob;
    logic [15:0] kind;
    logic [7:0]  rnd;
    logic        wr_ready;
    logic        gen_en, wr_en, busy, done;
    logic [9:0]  wr_addr;
    logic [3:0]  wr_data;

    logic [7:0]  ts_rnd;
    logic [31:0] ts_prob;
    logic [15:0] ts_kind;
    logic [3:0]  ts_tile;

    always #5 clk = ~clk;

    cave_filler #(.WIDTH(W), .HEIGHT(H), .ADDR_W(10)) dut (
        .clk(clk), .res(res), .start(start), .prob(prob), .kind(kind), .rnd(rnd),
        .gen_en(gen_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .busy(busy), .done(done)
    );

    tile_select u_ts (.rnd_i(ts_rnd), .prob_i(ts_prob), .kind_i(ts_kind), .tile_o(ts_tile));

    typedef struct {
        logic [7:0]  rnd;
        logic [31:0] prob;
        logic [15:0] kind;
        logic [3:0]  exp;
    } tv_t;

    tv_t tab [10];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase 0 idle, 1 filling, 2 done; m_n is the cell index.
    int          m_phase = 0;
    int          m_n = 0;
    logic [31:0] m_p = '0;
    logic [15:0] m_k = '0;
    logic [7:0]  rnd_tab [N];
    logic [3:0]  obs [N];
    int cnt_wr, cnt_gen, cnt_done, cyc_idx, done_at;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Highest-index object whose threshold exceeds r, else dirt.
    function automatic logic [3:0] ref_tile(input int r, input logic [31:0] p, input logic [15:0] k);
        for (int i = 3; i >= 0; i--) begin
            if (r < int'((p >> (8 * i)) & 32'hFF)) return 4'((k >> (4 * i)) & 16'hF);
        end
        return TILE_DIRT;
    endfunction

    // One clock: drive, check against model, then advance model for the edge.
    task automatic cycle(input logic [7:0] r, input logic rdy, input logic st, input logic rs);
        int  row, col, a;
        bit  border;
        @(negedge clk);
        rnd = r; wr_ready = rdy; start = st; res = rs;
        #1;
        chk("wr_en", 32'(wr_en), 32'(m_phase == 1));
        chk("busy",  32'(busy),  32'(m_phase == 1));
        chk("done",  32'(done),  32'(m_phase == 2));
        if (m_phase == 1) begin
            row = m_n / W;
            col = m_n % W;
            border = (row == 0) || (row == H - 1) || (col == 0) || (col == W - 1);
            chk("wr_addr", 32'(wr_addr), 32'(m_n));
            chk("wr_data", 32'(wr_data), 32'(border ? TILE_STEEL : ref_tile(int'(r), m_p, m_k)));
            chk("gen_en",  32'(gen_en),  32'(!border && rdy));
        end else begin
            chk("gen_en_idle", 32'(gen_en), 32'(0));
        end
        a = int'(wr_addr);
        if (wr_en && rdy && a < N) obs[a] = wr_data;
        if (wr_en && rdy) cnt_wr++;
        if (gen_en) cnt_gen++;
        if (done) begin
            cnt_done++;
            done_at = cyc_idx;
        end
        cyc_idx++;
        if (rs) begin
            m_phase = 0;
            m_n = 0;
        end else begin
            case (m_phase)
                0: if (st) begin m_phase = 1; m_n = 0; m_p = prob; m_k = kind; end
                1: if (rdy) begin
                       if (m_n == N - 1) m_phase = 2;
                       else m_n++;
                   end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic clear_counts();
        cnt_wr = 0; cnt_gen = 0; cnt_done = 0; cyc_idx = 0; done_at = -1;
        for (int i = 0; i < N; i++) obs[i] = 4'hF;
    endtask

    // rmode: 0 always ready, 1 random stalls, 2 three-cycle stall on cell 5.
    // mess: re-pulse start mid-fill and in DONE, and change prob mid-fill.
    task automatic run_fill(input int rmode, input bit mess);
        int   stall;
        int   guard;
        logic rdy, st;
        clear_counts();
        stall = 0;
        guard = 0;
        cycle(rnd_tab[0], 1'b1, 1'b1, 1'b0);
        while (m_phase != 0 && guard < 200) begin
            rdy = 1'b1;
            if (rmode == 1) rdy = ($urandom_range(0, 3) != 0);
            if (rmode == 2 && m_n == 5 && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end
            st = mess && (guard == 3 || m_phase == 2);
            if (mess && guard == 4) prob = ~prob;
            cycle(rnd_tab[m_n], rdy, st, 1'b0);
            guard++;
        end
        if (guard >= 200) chk("fill_timeout", 32'(guard), 32'(0));
    endtask

    task automatic set_rnd_tab(input logic [7:0] v);
        for (int i = 0; i < N; i++) rnd_tab[i] = v;
    endtask

    initial begin
        int guard;
        tab[0] = '{8'd0,   32'h0000_0000, 16'h0000, TILE_DIRT};
        tab[1] = '{8'd127, 32'h0000_0080, 16'h0003, TILE_BOULDER};
        tab[2] = '{8'd128, 32'h0000_0080, 16'h0003, TILE_DIRT};
        tab[3] = '{8'd10,  32'hC8C8_C8C8, 16'h4321, TILE_DIAMOND};
        tab[4] = '{8'd254, 32'h0000_00FF, 16'h0002, TILE_BRICK};
        tab[5] = '{8'd255, 32'h0000_00FF, 16'h0002, TILE_DIRT};
        tab[6] = '{8'd50,  32'h0040_0020, 16'h0A4B, 4'hA};
        tab[7] = '{8'd0,   32'h0100_0000, 16'h7000, TILE_STEEL};
        tab[8] = '{8'd1,   32'h0100_0000, 16'h7000, TILE_DIRT};
        tab[9] = '{8'd100, 32'h6564_6362, 16'h5678, 4'h5};

        res = 1'b1; start = 1'b0; prob = '0; kind = '0; rnd = '0; wr_ready = 1'b1;
        ts_rnd = '0; ts_prob = '0; ts_kind = '0;

        // Tile selection, directed vectors then random against the model.
        for (int i = 0; i < 10; i++) begin
            ts_rnd = tab[i].rnd; ts_prob = tab[i].prob; ts_kind = tab[i].kind;
            #1;
            chk($sformatf("tv%0d", i), 32'(ts_tile), 32'(tab[i].exp));
        end
        for (int i = 0; i < 300; i++) begin
            ts_rnd = 8'($urandom); ts_prob = $urandom; ts_kind = 16'($urandom);
            #1;
            chk("ts_rand", 32'(ts_tile), 32'(ref_tile(int'(ts_rnd), ts_prob, ts_kind)));
        end

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_wr_en",   32'(wr_en),   32'(0));
        chk("rst_busy",    32'(busy),    32'(0));
        chk("rst_done",    32'(done),    32'(0));
        chk("rst_gen_en",  32'(gen_en),  32'(0));
        chk("rst_wr_addr", 32'(wr_addr), 32'(0));
        chk("rst_wr_data", 32'(wr_data), 32'(TILE_DIRT));
        cycle(8'd0, 1'b1, 1'b0, 1'b0);

        // Plain fill: steel border, dirt interior, latency.
        prob = '0; kind = '0; set_rnd_tab(8'h5A);
        run_fill(0, 1'b0);
        chk("t1_writes", 32'(cnt_wr),   32'(N));
        chk("t1_gens",   32'(cnt_gen),  32'(2));
        chk("t1_dones",  32'(cnt_done), 32'(1));
        chk("t1_lat",    32'(done_at),  32'(N + 1));
        chk("t1_a0",     32'(obs[0]),   32'(TILE_STEEL));
        chk("t1_a5",     32'(obs[5]),   32'(TILE_DIRT));
        chk("t1_a6",     32'(obs[6]),   32'(TILE_DIRT));
        chk("t1_a7",     32'(obs[7]),   32'(TILE_STEEL));

        // Strict threshold boundary.
        prob = 32'h0000_0080; kind = {12'h0, TILE_BOULDER};
        set_rnd_tab(8'h00); rnd_tab[5] = 8'd127; rnd_tab[6] = 8'd128;
        run_fill(0, 1'b0);
        chk("t2_a5", 32'(obs[5]), 32'(TILE_BOULDER));
        chk("t2_a6", 32'(obs[6]), 32'(TILE_DIRT));

        // Overlapping matches: highest index wins.
        prob = 32'hC8C8_C8C8; kind = 16'h4321; set_rnd_tab(8'd10);
        run_fill(0, 1'b0);
        chk("t3_a5", 32'(obs[5]), 32'(TILE_DIAMOND));
        chk("t3_a6", 32'(obs[6]), 32'(TILE_DIAMOND));

        // Three-cycle stall on address 5.
        prob = 32'h0000_0080; kind = 16'h0003; set_rnd_tab(8'd20);
        run_fill(2, 1'b0);
        chk("t4_writes", 32'(cnt_wr),  32'(N));
        chk("t4_gens",   32'(cnt_gen), 32'(2));
        chk("t4_lat",    32'(done_at), 32'(N + 4));
        chk("t4_a5",     32'(obs[5]),  32'(TILE_BOULDER));

        // Reset after the fourth accepted write, then restart.
        prob = '0; kind = '0; set_rnd_tab(8'h33);
        clear_counts();
        cycle(rnd_tab[0], 1'b1, 1'b1, 1'b0);
        guard = 0;
        while (cnt_wr < 4 && guard < 50) begin
            cycle(rnd_tab[m_n], 1'b1, 1'b0, 1'b0);
            guard++;
        end
        if (guard >= 50) chk("t5_timeout", 32'(guard), 32'(0));
        cycle(rnd_tab[m_n], 1'b0, 1'b0, 1'b1);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        chk("t5_wr_addr", 32'(wr_addr), 32'(0));
        chk("t5_wr_data", 32'(wr_data), 32'(TILE_DIRT));
        repeat (5) cycle(8'h00, 1'b1, 1'b0, 1'b0);
        chk("t5_no_done", 32'(cnt_done), 32'(0));
        run_fill(0, 1'b0);
        chk("t5_writes", 32'(cnt_wr),   32'(N));
        chk("t5_dones",  32'(cnt_done), 32'(1));

        // Start re-pulsed while busy and in DONE; prob changed mid-fill.
        prob = 32'h0000_0080; kind = 16'h0003; set_rnd_tab(8'd10);
        run_fill(0, 1'b1);
        chk("t6_writes", 32'(cnt_wr),   32'(N));
        chk("t6_dones",  32'(cnt_done), 32'(1));
        chk("t6_a5",     32'(obs[5]),   32'(TILE_BOULDER));
        repeat (3) cycle(8'h00, 1'b1, 1'b0, 1'b0);

        // Random fills with random back-pressure.
        for (int f = 0; f < 8; f++) begin
            prob = $urandom; kind = 16'($urandom);
            for (int i = 0; i < N; i++) rnd_tab[i] = 8'($urandom);
            run_fill(1, 1'b0);
            chk("rf_writes", 32'(cnt_wr),   32'(N));
            chk("rf_gens",   32'(cnt_gen),  32'(2));
            chk("rf_dones",  32'(cnt_done), 32'(1));
            chk("rf_a5",     32'(obs[5]),   32'(ref_tile(int'(rnd_tab[5]), prob, kind)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
